// File: rtl/corelet_pkg.sv
// Shared types and helpers for the corelet SFU stage.
package corelet_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Lane c of a packed vector lives at [c*bw +: bw].
    function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned bw);
        return lane * bw;
    endfunction

endpackage

// File: rtl/corelet_sfu_lane.sv
// One SFU lane: signed accumulate add plus ReLU on the drain path.
// CORELET_SFU_SAT_EN selects a saturating add; otherwise the add wraps.
module sfu_lane #(
    parameter int unsigned PSUM_BW = 16
) (
    input  logic [PSUM_BW-1:0] acc_a,
    input  logic [PSUM_BW-1:0] acc_b,
    output logic [PSUM_BW-1:0] sum_c,
    input  logic [PSUM_BW-1:0] rd_val,
    input  logic               relu_en,
    output logic [PSUM_BW-1:0] rd_out_c
);

`ifdef CORELET_SFU_SAT_EN
    localparam int unsigned EW = PSUM_BW + 1;

    logic signed [EW-1:0] wide;

    // One guard bit: top two bits disagreeing means the add overflowed.
    always_comb begin
        wide = EW'($signed(acc_a)) + EW'($signed(acc_b));
        if (wide[EW-1] != wide[EW-2]) begin
            sum_c = wide[EW-1] ? {1'b1, {(PSUM_BW-1){1'b0}}}
                               : {1'b0, {(PSUM_BW-1){1'b1}}};
        end else begin
            sum_c = wide[PSUM_BW-1:0];
        end
    end
`else
    always_comb begin
        sum_c = acc_a + acc_b;
    end
`endif

    always_comb begin
        rd_out_c = (relu_en && rd_val[PSUM_BW-1]) ? '0 : rd_val;
    end

endmodule

// File: rtl/corelet_sfu.sv
// Accumulating special-function stage between OFIFO and PSUM SRAM write port.
// Build option CORELET_SFU_SAT_EN makes the lane adds saturate instead of wrap.
module corelet_sfu
    import corelet_pkg::*;
#(
    parameter int unsigned COL     = 8,
    parameter int unsigned PSUM_BW = 16,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned PASS_BW = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [PASS_BW-1:0]       cfg_passes,
    input  logic                     cfg_relu,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [COL*PSUM_BW-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [COL*PSUM_BW-1:0]   out_data,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned VW = COL * PSUM_BW;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t             state_q, state_d;
    logic [AW-1:0]      wr_addr_q, wr_addr_d;
    logic [AW-1:0]      rd_addr_q, rd_addr_d;
    logic [PASS_BW-1:0] pass_q, pass_d;
    logic [PASS_BW-1:0] k_last_q, k_last_d;
    logic               relu_q, relu_d;

    logic               in_ready_d, out_valid_d, busy_d, done_d;
    logic [VW-1:0]      out_data_d;

    logic [VW-1:0]      mem_q [DEPTH];
    logic [VW-1:0]      sum_vec;
    logic [VW-1:0]      rd_vec;
    logic               in_fire, out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    for (genvar c = 0; c < COL; c++) begin : g_lane
        localparam int unsigned LO = lane_lo(c, PSUM_BW);
        sfu_lane #(.PSUM_BW(PSUM_BW)) u_lane (
            .acc_a    (mem_q[wr_addr_q][LO +: PSUM_BW]),
            .acc_b    (in_data[LO +: PSUM_BW]),
            .sum_c    (sum_vec[LO +: PSUM_BW]),
            .rd_val   (mem_q[rd_addr_d][LO +: PSUM_BW]),
            .relu_en  (relu_q),
            .rd_out_c (rd_vec[LO +: PSUM_BW])
        );
    end

    // Next-state and counter logic.
    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        pass_d    = pass_q;
        k_last_d  = k_last_q;
        relu_d    = relu_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ACC;
                    wr_addr_d = '0;
                    pass_d    = '0;
                    relu_d    = cfg_relu;
                    k_last_d  = (cfg_passes == '0) ? '0 : cfg_passes - PASS_BW'(1);
                end
            end
            ACC: begin
                if (in_fire) begin
                    if (wr_addr_q == LAST) begin
                        wr_addr_d = '0;
                        pass_d    = pass_q + PASS_BW'(1);
                        if (pass_q == k_last_q) begin
                            state_d   = DRAIN;
                            rd_addr_d = '0;
                        end
                    end else begin
                        wr_addr_d = wr_addr_q + AW'(1);
                    end
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    if (rd_addr_q == LAST) begin
                        state_d   = IDLE;
                        rd_addr_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        rd_addr_d = rd_addr_q + AW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are decoded from the next state; out_data preloads buf[rd_addr_d].
    always_comb begin
        in_ready_d  = (state_d == ACC);
        out_valid_d = (state_d == DRAIN);
        busy_d      = (state_d != IDLE);
        out_data_d  = out_valid_d ? rd_vec : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            pass_q    <= '0;
            k_last_q  <= '0;
            relu_q    <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            pass_q    <= pass_d;
            k_last_q  <= k_last_d;
            relu_q    <= relu_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // Tile buffer holds no reset; every entry is loaded on pass 0 before use.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem_q[wr_addr_q] <= (pass_q == '0) ? in_data : sum_vec;
        end
    end

endmodule

// File: tb/tb_corelet_sfu.sv
// Scoreboard bench for corelet_sfu (COL=8, PSUM_BW=16, DEPTH=4).
module tb_corelet_sfu;

    localparam int unsigned COL     = 8;
    localparam int unsigned BW      = 16;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned PASS_BW = 8;
    localparam int unsigned VW      = COL * BW;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [PASS_BW-1:0] cfg_passes;
    logic               cfg_relu;
    logic               in_valid;
    logic               in_ready;
    logic [VW-1:0]      in_data;
    logic               out_valid;
    logic               out_ready;
    logic [VW-1:0]      out_data;
    logic               busy;
    logic               done;

    corelet_sfu #(
        .COL(COL), .PSUM_BW(BW), .DEPTH(DEPTH), .PASS_BW(PASS_BW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_passes(cfg_passes),
        .cfg_relu(cfg_relu), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_out_cyc = -10;
    int in_hs = 0;
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] in_vecs [3][DEPTH];
    logic [VW-1:0] exp_vecs [DEPTH];
    logic          stall_prev = 1'b0;
    logic [VW-1:0] data_prev = '0;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [VW-1:0] vec_alt(input int a, input int b);
        logic [VW-1:0] v;
        v = '0;
        for (int c = 0; c < COL; c++) v[c*BW +: BW] = (c % 2 == 0) ? BW'(a) : BW'(b);
        return v;
    endfunction

    function automatic logic [VW-1:0] vec_ramp(input int i);
        logic [VW-1:0] v;
        v = '0;
        for (int c = 0; c < COL; c++) v[c*BW +: BW] = BW'(10 * i + c - 15);
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every output handshake and checks hold/zero/done rules.
    always @(negedge clk) begin
        if (reset) begin
            if (stall_prev) begin
                chk_bit("hold_valid", out_valid, 1'b1);
                chk("hold_data", out_data, data_prev);
            end
            if (!out_valid) chk("zero_when_invalid", out_data, '0);
            if (done) chk_int("done_timing", cyc, last_out_cyc + 1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_unexpected actual=%h required=none", out_data);
                end else begin
                    chk("out_data", out_data, exp_q.pop_front());
                end
                last_out_cyc = cyc;
            end
            if (in_valid && in_ready) in_hs++;
            stall_prev = out_valid && !out_ready;
            data_prev  = out_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic start_tile(input int k, input logic relu);
        @(posedge clk); #1;
        start = 1'b1;
        cfg_passes = PASS_BW'(k);
        cfg_relu = relu;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_passes = PASS_BW'(7);
        cfg_relu = ~relu;
        chk_bit("start_in_ready", in_ready, 1'b1);
        chk_bit("start_busy", busy, 1'b1);
    endtask

    task automatic send_vec(input logic [VW-1:0] d, input logic gaps);
        logic ok;
        ok = 1'b0;
        if (gaps) repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data = d;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        chk_bit("in_accept", ok, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data = '0;
    endtask

    task automatic wait_done();
        logic got;
        got = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; break; end
        end
        chk_bit("done_seen", got, 1'b1);
        chk_bit("done_busy", busy, 1'b0);
        chk_int("drained_all", exp_q.size(), 0);
        @(negedge clk);
        chk_bit("done_one_cycle", done, 1'b0);
    endtask

    task automatic run_tile(input int k, input logic relu, input logic gaps);
        int np;
        np = (k == 0) ? 1 : k;
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(exp_vecs[i]);
        start_tile(k, relu);
        for (int p = 0; p < np; p++)
            for (int e = 0; e < DEPTH; e++) send_vec(in_vecs[p][e], gaps);
        chk_bit("turn_in_ready", in_ready, 1'b0);
        chk_bit("turn_out_valid", out_valid, 1'b1);
        wait_done();
    endtask

    initial begin
        int hs0;
        reset = 1'b0; start = 1'b0; cfg_passes = '0; cfg_relu = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_bit("rst_in_ready", in_ready, 1'b0);
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_done", done, 1'b0);
        reset = 1'b1;

        // K=1 pass-through ramp, then K=0 behaving as K=1
        for (int i = 0; i < DEPTH; i++) begin
            in_vecs[0][i] = vec_ramp(i);
            exp_vecs[i] = vec_ramp(i);
        end
        run_tile(1, 1'b0, 1'b0);
        run_tile(0, 1'b0, 1'b0);

        // K=3, every lane 100, gapped input
        for (int i = 0; i < DEPTH; i++) begin
            for (int p = 0; p < 3; p++) in_vecs[p][i] = vec_alt(100, 100);
            exp_vecs[i] = vec_alt(300, 300);
        end
        hs0 = in_hs;
        run_tile(3, 1'b0, 1'b1);
        chk_int("hs_count_k3", in_hs - hs0, 12);

        // K=2 with and without ReLU
        for (int i = 0; i < DEPTH; i++) begin
            in_vecs[0][i] = vec_alt(-5, 7);
            in_vecs[1][i] = vec_alt(0, 0);
            exp_vecs[i] = vec_alt(0, 7);
        end
        run_tile(2, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) exp_vecs[i] = vec_alt(-5, 7);
        run_tile(2, 1'b0, 1'b0);

        // K=2 overflow: saturate or wrap
        for (int i = 0; i < DEPTH; i++) begin
            in_vecs[0][i] = vec_alt(30000, -30000);
            in_vecs[1][i] = vec_alt(30000, -30000);
`ifdef CORELET_SFU_SAT_EN
            exp_vecs[i] = vec_alt(32767, -32768);
`else
            exp_vecs[i] = vec_alt(-5536, 5536);
`endif
        end
        run_tile(2, 1'b0, 1'b0);

        // Drain stall at rd_addr=1 with a start pulse that must be ignored
        for (int i = 0; i < DEPTH; i++) begin
            in_vecs[0][i] = vec_ramp(i + 3);
            exp_vecs[i] = vec_ramp(i + 3);
            exp_q.push_back(exp_vecs[i]);
        end
        start_tile(1, 1'b0);
        for (int e = 0; e < DEPTH; e++) send_vec(in_vecs[0][e], 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        start = 1'b1;
        cfg_passes = PASS_BW'(1);
        @(posedge clk); #1;
        start = 1'b0;
        chk_bit("drain_start_busy", busy, 1'b1);
        chk_bit("drain_start_in_ready", in_ready, 1'b0);
        chk_bit("stall_out_valid", out_valid, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        wait_done();
        @(posedge clk); #1;
        chk_bit("no_new_tile_busy", busy, 0);
        chk_bit("no_new_tile_in_ready", in_ready, 0);

        // Reset at pass 1, wr_addr 2, then a clean tile
        for (int i = 0; i < DEPTH; i++) begin
            in_vecs[0][i] = vec_alt(50, -50);
            in_vecs[1][i] = vec_alt(9, 9);
        end
        start_tile(2, 1'b0);
        for (int e = 0; e < DEPTH; e++) send_vec(in_vecs[0][e], 1'b0);
        send_vec(in_vecs[1][0], 1'b0);
        send_vec(in_vecs[1][1], 1'b0);
        chk_bit("pre_abort_in_ready", in_ready, 1'b1);
        reset = 1'b0;
        #1;
        chk_bit("abort_in_ready", in_ready, 1'b0);
        chk_bit("abort_out_valid", out_valid, 1'b0);
        chk("abort_out_data", out_data, '0);
        chk_bit("abort_busy", busy, 1'b0);
        chk_bit("abort_done", done, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            in_vecs[0][i] = vec_alt(i + 1, i + 1);
            exp_vecs[i] = vec_alt(i + 1, i + 1);
        end
        run_tile(1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
